// File: rtl/flag_word_arbiter.sv
// flag_word_arbiter: round-robin arbiter that shares one 96-bit flag-word
// channel between NUM_REQ producers. A grant is held for a whole burst, which
// ends on req_last or on a beat limit. Byte enables mask each word on the way
// through, and the output is a registered valid/ready stage.
module flag_word_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BEATS = 16,
  parameter int WORD_W    = 96
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*WORD_W-1:0]   req_data,
  input  logic [NUM_REQ*WORD_W/8-1:0] req_be,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic [WORD_W-1:0]           out_data,
  output logic [2:0]                  out_src,
  output logic                        out_last,
  input  logic                        out_ready
);

  localparam int BYTES = WORD_W / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Zero every byte whose enable bit is clear. There is no lane-level
  // behaviour; the 32-bit lanes are just groups of four bytes.
  function automatic logic [WORD_W-1:0] apply_be(input logic [WORD_W-1:0] word,
                                                 input logic [BYTES-1:0]  be);
    logic [WORD_W-1:0] res;
    res = {WORD_W{1'b0}};
    for (int k = 0; k < BYTES; k++) begin
      res[8*k +: 8] = word[8*k +: 8] & {8{be[k]}};
    end
    return res;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [2:0]          grant_r;
  logic [2:0]          rr_ptr_r;
  logic [7:0]          beat_cnt_r;
  logic                out_valid_r;
  logic [WORD_W-1:0]   out_data_r;
  logic [2:0]          out_src_r;
  logic                out_last_r;

  logic [7:0]          valid8_s;
  logic [3:0]          sum_s;
  logic [3:0]          cand_s;
  logic                pick_found_s;
  logic [2:0]          pick_idx_s;
  logic [NUM_REQ-1:0]  gmask_s;
  logic                sel_valid_s;
  logic                sel_last_s;
  logic [WORD_W-1:0]   sel_data_s;
  logic [BYTES-1:0]    sel_be_s;
  logic                slot_free_s;
  logic                xfer_s;
  logic                release_s;
  logic [2:0]          rr_next_s;
  logic [NUM_REQ-1:0]  req_ready_s;

  assign valid8_s = 8'(req_valid);

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = 3'd0;
    sum_s        = 4'd0;
    cand_s       = 4'd0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum_s  = {1'b0, rr_ptr_r} + 4'(off);
      cand_s = (sum_s >= 4'(NUM_REQ)) ? (sum_s - 4'(NUM_REQ)) : sum_s;
      if (!pick_found_s && valid8_s[cand_s[2:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s[2:0];
      end else begin
        pick_idx_s   = pick_idx_s;
      end
    end
  end

  // One-hot view of the grant and an AND-OR mux of the granted requester.
  always_comb begin
    gmask_s     = {NUM_REQ{1'b0}};
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = {WORD_W{1'b0}};
    sel_be_s    = {BYTES{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      gmask_s[i]  = (grant_r == 3'(i));
      sel_valid_s = sel_valid_s | (req_valid[i] & gmask_s[i]);
      sel_last_s  = sel_last_s  | (req_last[i]  & gmask_s[i]);
      sel_data_s  = sel_data_s  | (req_data[WORD_W*i +: WORD_W] & {WORD_W{gmask_s[i]}});
      sel_be_s    = sel_be_s    | (req_be[BYTES*i +: BYTES]     & {BYTES{gmask_s[i]}});
    end
  end

  // The output slot can take a word when empty or being drained this cycle.
  assign slot_free_s = !out_valid_r || out_ready;
  assign xfer_s      = (state_r == BUSY) && sel_valid_s && slot_free_s;
  assign release_s   = sel_last_s || (beat_cnt_r == 8'(MAX_BEATS - 1));
  assign rr_next_s   = (grant_r == 3'(NUM_REQ - 1)) ? 3'd0 : (grant_r + 3'd1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and the per-requester accept; nobody is accepted in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    req_ready_s = {NUM_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        req_ready_s = gmask_s & {NUM_REQ{slot_free_s}};
        if (xfer_s && release_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        req_ready_s = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // Grant, round-robin pointer and beat counter bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r    <= 3'd0;
      rr_ptr_r   <= 3'd0;
      beat_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            grant_r    <= pick_idx_s;
            beat_cnt_r <= 8'd0;
          end else begin
            grant_r    <= grant_r;
            beat_cnt_r <= beat_cnt_r;
          end
        end
        BUSY: begin
          if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
            if (release_s) begin
              rr_ptr_r <= rr_next_s;
            end else begin
              rr_ptr_r <= rr_ptr_r;
            end
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        default: begin
          grant_r    <= 3'd0;
          rr_ptr_r   <= 3'd0;
          beat_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  // Registered output stage: load on transfer, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WORD_W{1'b0}};
      out_src_r   <= 3'd0;
      out_last_r  <= 1'b0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= apply_be(sel_data_s, sel_be_s);
      out_src_r   <= grant_r;
      out_last_r  <= release_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign req_ready = req_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_flag_word_arbiter.sv
// Bench for flag_word_arbiter: per-requester beat queues drive the inputs,
// expected words go into a scoreboard queue, and a monitor compares every
// word the consumer accepts.
module tb_flag_word_arbiter;

  localparam int NREQ = 4;
  localparam int MAXB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*96-1:0] req_data;
  logic [NREQ*12-1:0] req_be;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [95:0]       out_data;
  logic [2:0]        out_src;
  logic              out_last;
  logic              out_ready;

  typedef struct packed {
    logic [95:0] data;
    logic [11:0] be;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [95:0] data;
    logic [2:0]  src;
    logic        last;
  } exp_t;

  beat_t     rq [NREQ][$];
  exp_t      exp_q [$];
  int        pop_cyc [$];
  exp_t      mon_e;
  logic [NREQ-1:0] hs;
  int        asserts = 0;
  int        fails   = 0;
  int        pop_cnt = 0;
  int        cyc     = 0;

  flag_word_arbiter #(.NUM_REQ(NREQ), .MAX_BEATS(MAXB), .WORD_W(96)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_be    (req_be),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp accepted words.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records handshakes and checks each accepted word against the scoreboard.
  always @(negedge clk) begin
    hs = req_valid & req_ready;
    if (!rst) begin
      asserts++;
      if (!$onehot0(req_ready)) begin
        fails++;
        $display("FAIL ready_onehot: req_ready=%b, required at most one bit set", req_ready);
      end
      if (out_valid && out_ready) begin
        asserts++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word: src=%0d data=%h, no word expected", out_src, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_src !== mon_e.src || out_last !== mon_e.last || out_data !== mon_e.data) begin
            fails++;
            $display("FAIL out_word: got src=%0d last=%b data=%h, expected src=%0d last=%b data=%h",
                     out_src, out_last, out_data, mon_e.src, mon_e.last, mon_e.data);
          end
        end
        pop_cnt++;
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Requester driver: retire accepted beats, present the next queued one.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = rq[i][0].last;
        req_data[96*i +: 96] = rq[i][0].data;
        req_be[12*i +: 12]   = rq[i][0].be;
      end else begin
        req_valid[i]         = 1'b0;
        req_last[i]          = 1'b0;
        req_data[96*i +: 96] = 96'd0;
        req_be[12*i +: 12]   = 12'd0;
      end
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input int i, input logic [95:0] d, input logic [11:0] be, input logic l);
    beat_t b;
    b.data = d;
    b.be   = be;
    b.last = l;
    rq[i].push_back(b);
  endtask

  task automatic expect_word(input int src, input logic [95:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.src  = 3'(src);
    e.last = l;
    exp_q.push_back(e);
  endtask

  function automatic logic [95:0] word_of(input int src, input int n);
    return {32'hF1A6_0000 + 32'(src), 32'(n), 32'hBEEF_0000 + 32'(n)};
  endfunction

  function automatic bit all_empty();
    bit e;
    e = (exp_q.size() == 0);
    for (int i = 0; i < NREQ; i++) e = e && (rq[i].size() == 0);
    return e;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    bit done;
    int k;
    done = 1'b0;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk); #1;
      k++;
      done = all_empty();
    end
    asserts++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) rq[i].delete();
    end
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (pop_cnt < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    asserts++;
    if (pop_cnt < target) begin
      fails++;
      $display("FAIL %s_timeout: %0d words seen, required %0d", name, pop_cnt, target);
    end
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst       = 1'b1;
    out_ready = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    req_be    = '0;
    hs        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_out_data",  out_data,       96'd0);
    chk("rst_out_src",   96'(out_src),   96'd0);
    chk("rst_out_last",  96'(out_last),  96'd0);
    chk("rst_req_ready", 96'(req_ready), 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: requesters 0 and 2, single-beat bursts; 0 first, 2 two cycles later.
    b = pop_cyc.size();
    send(0, word_of(0, 1), 12'hFFF, 1'b1);
    send(2, word_of(2, 1), 12'hFFF, 1'b1);
    expect_word(0, word_of(0, 1), 1'b1);
    expect_word(2, word_of(2, 1), 1'b1);
    wait_idle("t1", 50);
    if (pop_cyc.size() >= b + 2) chk("t1_gap", 96'(pop_cyc[b+1] - pop_cyc[b]), 96'd2);
    else chk("t1_count", 96'(pop_cyc.size() - b), 96'd2);

    // rr_ptr is now 3: with 0 and 3 both valid, 3 wins. Also be=000 and be=801.
    send(0, 96'hFFEE_DDCC_BBAA_9988_7766_5544, 12'h801, 1'b1);
    send(3, word_of(3, 1), 12'h000, 1'b1);
    expect_word(3, 96'd0, 1'b1);
    expect_word(0, 96'hFF00_0000_0000_0000_0000_0044, 1'b1);
    wait_idle("t1b", 50);

    // Test 2: byte-enable masking on requester 1.
    send(1, 96'h0123_4567_89AB_CDEF_0011_2233, 12'h0F0, 1'b1);
    expect_word(1, 96'h0000_0000_89AB_CDEF_0000_0000, 1'b1);
    wait_idle("t2", 50);

    // Test 3: requester 3 streams 8 beats with no last; forced release every 4 beats.
    b = pop_cyc.size();
    for (int n = 1; n <= 8; n++) begin
      send(3, word_of(3, 100 + n), 12'hFFF, 1'b0);
      expect_word(3, word_of(3, 100 + n), (n == 4) || (n == 8));
    end
    wait_idle("t3", 100);
    if (pop_cyc.size() >= b + 5) begin
      chk("t3_stream_gap", 96'(pop_cyc[b+1] - pop_cyc[b]), 96'd1);
      chk("t3_rearb_gap",  96'(pop_cyc[b+4] - pop_cyc[b+3]), 96'd2);
    end else begin
      chk("t3_count", 96'(pop_cyc.size() - b), 96'd8);
    end

    // Test 4: consumer stalls 5 cycles mid-burst; output holds, no accept.
    b = pop_cnt;
    for (int n = 1; n <= 6; n++) begin
      send(3, word_of(3, 200 + n), 12'hFFF, n == 6);
      expect_word(3, word_of(3, 200 + n), (n == 4) || (n == 6));
    end
    wait_pops("t4_start", b + 2, 50);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("t4_hold_valid", 96'(out_valid), 96'd1);
      chk("t4_hold_ready", 96'(req_ready), 96'd0);
      if (exp_q.size() > 0) begin
        chk("t4_hold_data", out_data,        exp_q[0].data);
        chk("t4_hold_src",  96'(out_src),    96'(exp_q[0].src));
        chk("t4_hold_last", 96'(out_last),   96'(exp_q[0].last));
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("t4", 100);

    // Test 5: all four continuously valid with single-beat bursts: 0,1,2,3 repeating.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        send(i, word_of(i, 300 + r), 12'hFFF, 1'b1);
        expect_word(i, word_of(i, 300 + r), 1'b1);
      end
    end
    wait_idle("t5", 200);

    // Test 6: move rr_ptr to 2, then reset on beat 2 of a 5-beat burst from 3.
    send(1, word_of(1, 400), 12'hFFF, 1'b1);
    expect_word(1, word_of(1, 400), 1'b1);
    wait_idle("t6a", 50);
    b = pop_cnt;
    for (int n = 1; n <= 5; n++) begin
      send(3, word_of(3, 500 + n), 12'hFFF, n == 5);
      expect_word(3, word_of(3, 500 + n), n == 5);
    end
    wait_pops("t6_start", b + 1, 50);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_out_valid", 96'(out_valid), 96'd0);
    chk("t6_rst_req_ready", 96'(req_ready), 96'd0);
    #1;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    @(negedge clk); #1;
    rst = 1'b0;
    send(1, word_of(1, 600), 12'hFFF, 1'b1);
    send(2, word_of(2, 600), 12'hFFF, 1'b1);
    expect_word(1, word_of(1, 600), 1'b1);
    expect_word(2, word_of(2, 600), 1'b1);
    wait_idle("t6b", 50);

    repeat (3) @(negedge clk);
    chk("final_scoreboard_empty", 96'(exp_q.size()), 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/flag_word_arbiter.md
Name: flag_word_arbiter

Overview:
- Round-robin arbiter sharing one 96-bit flag-word output channel between NUM_REQ requesters.
- Each flag word is the packed 96-bit union type used across the design. Its views are 3 x 32-bit lanes or 12 x 8-bit bytes.
- Grants are held for a whole burst, terminated by last or by a beat limit.
- Byte enables are applied on the way through.
- Output is registered with a valid/ready handshake; the block sits between flag producers and the single flag consumer.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- MAX_BEATS, 16, maximum beats per grant before forced release (1..255).
- WORD_W, 96, flag word width; fixed at 96, 12 bytes.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester word valid.
- req_last  input  NUM_REQ  per-requester last beat of burst.
- req_data  input  NUM_REQ*96  requester i word at bits [96i+95:96i].
- req_be  input  NUM_REQ*12  requester i byte enables at bits [12i+11:12i].
- req_ready  output  NUM_REQ  per-requester accept.
- out_valid  output  1  output word valid.
- out_data  output  96  masked flag word.
- out_src  output  3  index of the granted requester for the current out word.
- out_last  output  1  burst end, natural or forced.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (rst=1 at a clk edge) clears all state:
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant=0.
  - out_valid=0, out_data=0, out_src=0, out_last=0.
  - req_ready=0 (combinationally 0 while in IDLE).
- Reset mid-burst discards the burst and any un-accepted out word. Nothing is replayed.
- States:
  - IDLE: req_ready all 0. If any req_valid is set, grant = first set index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. Then go to BUSY next cycle, beat_cnt=0. With no valid, stay in IDLE.
  - BUSY: req_ready[grant] = !out_valid || out_ready; all other req_ready bits are 0.
- Transfer: occurs when req_valid[grant] && req_ready[grant]. On the same edge:
  - out_valid=1 and out_src=grant.
  - out_data byte k = req_be bit k ? byte k of req_data : 8'h00.
  - beat_cnt increments.
- Release condition: req_last[grant], or beat_cnt == MAX_BEATS-1 at the transfer (forced release).
  - out_last = 1 on the releasing beat, else 0.
  - On release: state goes to IDLE and rr_ptr = (grant+1) mod NUM_REQ, wrapping NUM_REQ-1 -> 0.
- Output hold: out_valid && !out_ready holds out_data, out_src and out_last stable. out_valid clears on out_ready with no new transfer.
- Throughput: in BUSY with out_ready held high, 1 word/cycle.
- Latency:
  - The first beat is accepted no earlier than 1 cycle after req_valid rises in IDLE (arbitration cycle).
  - The word appears on out_* the cycle after acceptance.
  - Re-arbitration costs 1 idle cycle between bursts.
- Granted requester dropping req_valid mid-burst: grant is kept, with no timeout; waiting cycles do not advance beat_cnt.
- Non-granted requesters are never accepted, even while valid.
- NUM_REQ=1: rr_ptr stays 0, and the block degenerates to a burst-limited register slice.
- req_be=12'h000 passes an all-zero word; it still counts as a beat.
- Lane view: 32-bit lane j = bytes 4j..4j+3. There is no lane-specific logic; masking is per byte only.

Test Plan:
1. Reset, then requesters 0 and 2 valid with last=1 each, out_ready=1 -> requester 0 word out first, then requester 2 word out two cycles later; rr_ptr=3 afterwards.
2. Requester 1 sends data 96'h0123_4567_89AB_CDEF_0011_2233, be=12'h0F0, last=1 -> out_data=96'h0000_0000_89AB_CDEF_0000_0000, out_src=1, out_last=1.
3. MAX_BEATS=4, requester 3 streams 6 words with last never set -> out_last=1 on beat 4 and grant released. Remaining 2 words come in a new burst after re-arbitration.
4. out_ready held 0 for 5 cycles mid-burst -> out_* stable, req_ready[grant]=0, no beat lost or duplicated; order is preserved after release.
5. All 4 requesters continuously valid, single-beat bursts -> grant sequence 0,1,2,3,0,... with wrap from 3 to 0.
6. Assert rst on beat 2 of a 5-beat burst -> next cycle out_valid=0, req_ready=0, rr_ptr=0; the next grant goes to the lowest valid index.
